// File: rtl/param_mode_counter.sv
// rtl/param_mode_counter.sv - parameterised up/down counter, free-run/one-shot, load/start/stop, terminal-count pulse
// Optional CE prescaler is built when COUNTER_PRESCALE_EN is defined.
module param_mode_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     PRESCALE = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CE,
    input  logic             START,
    input  logic             STOP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             DIR,
    input  logic             MODE,
    output logic [WIDTH-1:0] O,
    output logic             cout,
    output logic             BUSY
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    // Out-of-range parameters leave a named marker in the elaborated hierarchy.
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH) ||
        PRESCALE < 1 || PRESCALE > 256) begin : g_param_range_error
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] count_step;
    logic [WIDTH-1:0] load_clamped;
    logic             step_en;
    logic             at_term;
    logic             tick;

    assign step_en      = (state_q == S_RUN) && CE && !LOAD && !STOP;
    assign at_term      = DIR ? (count_q == '0) : (count_q == MAX_VAL);
    assign load_clamped = (LOAD_VAL > MAX_VAL) ? MAX_VAL : LOAD_VAL;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;

    assign tick = (ps_q == PS_W'(PRESCALE - 1));

    // Any load, start or return to IDLE restarts the step spacing from scratch.
    always_comb begin
        ps_d = ps_q;
        if (LOAD || (START && state_q == S_IDLE) || state_d == S_IDLE) begin
            ps_d = '0;
        end else if (step_en) begin
            ps_d = tick ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Wrap is explicit so MODULUS need not be a power of two.
    always_comb begin
        count_step = count_q;
        if (DIR) begin
            count_step = at_term ? MAX_VAL : count_q - WIDTH'(1);
        end else begin
            count_step = at_term ? '0 : count_q + WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (LOAD) begin
            count_d = load_clamped;
        end
        if (STOP && state_q == S_RUN) begin
            state_d = S_IDLE;
        end else if (START && state_q == S_IDLE) begin
            state_d = S_RUN;
        end else if (step_en && tick) begin
            count_d = count_step;
            if (MODE && at_term) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign O    = count_q;
    assign BUSY = (state_q == S_RUN);
    assign cout = step_en && tick && at_term;

endmodule
